// File: rtl/vga_mem_arbiter.sv
// Shares one single-port VRAM between the VGA pixel fetch (strict priority) and a
// 2-deep CPU request FIFO. The video path is pipelined so rgb_out and the syncs appear 2 clks after the scan position.
module vga_mem_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 12,
  parameter int FB_WORDS = 19200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        pixel_addr_x,
  input  logic [9:0]        pixel_addr_y,
  input  logic              display_in,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rgb_out,
  output logic              h_sync_out,
  output logic              v_sync_out
);

  localparam logic [ADDR_W:0] FB_LIMIT = FB_WORDS[ADDR_W:0];

  logic [9:0]        prev_x, prev_y;
  logic              run;
  logic              video_fetch;
  logic [ADDR_W-1:0] video_addr;

  logic [1:0]        count;
  logic              rd_ptr, wr_ptr;
  logic              fifo_we    [2];
  logic [ADDR_W-1:0] fifo_addr  [2];
  logic [DATA_W-1:0] fifo_wdata [2];
  logic              head_we;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic              head_in_fb;
  logic              push, pop;

  logic              vid_vld_p0, rd_vld_p0, rd_oob_p0;
  logic              disp_p0, hs_p0, vs_p0;

  // 4x4 pixel blocks of a 160-word-wide framebuffer
  assign video_addr  = ADDR_W'(pixel_addr_y[9:2]) * ADDR_W'(160) + ADDR_W'(pixel_addr_x[9:2]);
  assign video_fetch = !reset && display_in &&
                       ({pixel_addr_x, pixel_addr_y} != {prev_x, prev_y});

  assign head_we    = fifo_we[rd_ptr];
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_wdata = fifo_wdata[rd_ptr];
  assign head_in_fb = ({1'b0, head_addr} < FB_LIMIT);

  // run holds cpu_ready low for the first cycle after reset release
  assign cpu_ready = run && (count != 2'd2);
  assign push      = cpu_req && cpu_ready;
  assign pop       = !video_fetch && (count != 2'd0);

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = head_addr;
    mem_wdata = head_wdata;
    if (video_fetch) begin
      mem_en   = 1'b1;
      mem_addr = video_addr;
    end else if (pop && head_in_fb) begin
      mem_en = 1'b1;
      mem_we = head_we;
    end
  end

  assign cpu_rvalid = rd_vld_p0;
  assign cpu_rdata  = (rd_vld_p0 && !rd_oob_p0) ? mem_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_x <= 10'h3FF;
      prev_y <= 10'h3FF;
      run    <= 1'b0;
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      prev_x <= pixel_addr_x;
      prev_y <= pixel_addr_y;
      run    <= 1'b1;
      if (push) wr_ptr <= !wr_ptr;
      if (pop)  rd_ptr <= !rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we[wr_ptr]    <= cpu_we;
      fifo_addr[wr_ptr]  <= cpu_addr;
      fifo_wdata[wr_ptr] <= cpu_wdata;
    end
  end

  // stage p0: issue cycle -> return tags and first delay slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_vld_p0 <= 1'b0;
      rd_vld_p0  <= 1'b0;
      rd_oob_p0  <= 1'b0;
      disp_p0    <= 1'b0;
      hs_p0      <= 1'b1;
      vs_p0      <= 1'b1;
    end else begin
      vid_vld_p0 <= video_fetch;
      rd_vld_p0  <= pop && !head_we;
      rd_oob_p0  <= pop && !head_we && !head_in_fb;
      disp_p0    <= display_in;
      hs_p0      <= h_sync_in;
      vs_p0      <= v_sync_in;
    end
  end

  // stage p1: data return -> pixel and sync outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_out    <= '0;
      h_sync_out <= 1'b1;
      v_sync_out <= 1'b1;
    end else begin
      h_sync_out <= hs_p0;
      v_sync_out <= vs_p0;
      if (vid_vld_p0)    rgb_out <= mem_rdata;
      else if (!disp_p0) rgb_out <= '0;
    end
  end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Randomized bench for vga_mem_arbiter: a VRAM responder plus a request-queue /
// shadow-memory reference model checked against every output each cycle.
module tb_vga_mem_arbiter;
  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 12;
  localparam int FB_WORDS = 19200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [9:0]        pixel_addr_x, pixel_addr_y;
  logic              display_in, h_sync_in, v_sync_in;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [DATA_W-1:0] rgb_out;
  logic              h_sync_out, v_sync_out;

  vga_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_WORDS(FB_WORDS)) dut (
    .clk(clk), .reset(reset),
    .pixel_addr_x(pixel_addr_x), .pixel_addr_y(pixel_addr_y),
    .display_in(display_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .rgb_out(rgb_out), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out)
  );

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  logic [DATA_W-1:0] vram    [32768];
  logic [DATA_W-1:0] ref_mem [32768];

  req_t              q[$];
  logic [9:0]        m_prev_x, m_prev_y;
  bit                m_run, m_rv, m_vid, m_disp_d;
  bit                m_hs_d, m_vs_d, m_hs_out, m_vs_out;
  logic [DATA_W-1:0] m_rv_val, m_rgb, m_vid_val;

  bit                r_rd, r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ADDR_W-1:0] pix_word(input logic [9:0] x, input logic [9:0] y);
    int a;
    a = (int'(y) / 4) * 160 + (int'(x) / 4);
    return a[ADDR_W-1:0];
  endfunction

  task automatic model_reset();
    q.delete();
    m_prev_x = 10'h3FF; m_prev_y = 10'h3FF;
    m_run = 0; m_rv = 0; m_vid = 0; m_disp_d = 0;
    m_hs_d = 1; m_vs_d = 1; m_hs_out = 1; m_vs_out = 1;
    m_rv_val = '0; m_rgb = '0; m_vid_val = '0;
  endtask

  // Check outputs mid-cycle, advance the model across the coming edge, then act as VRAM.
  task automatic step();
    bit                fetch, pop, exp_en, exp_we, exp_ready, in_fb;
    logic [ADDR_W-1:0] exp_addr;
    req_t              h;
    @(negedge clk);
    fetch     = !reset && display_in && (pixel_addr_x != m_prev_x || pixel_addr_y != m_prev_y);
    pop       = !reset && !fetch && (q.size() > 0);
    exp_ready = m_run && (q.size() < 2);
    exp_en = 0; exp_we = 0; exp_addr = '0; in_fb = 0;
    if (pop) begin
      h     = q[0];
      in_fb = (int'(h.addr) < FB_WORDS);
    end
    if (fetch) begin
      exp_en = 1; exp_addr = pix_word(pixel_addr_x, pixel_addr_y);
    end else if (pop && in_fb) begin
      exp_en = 1; exp_we = h.we; exp_addr = h.addr;
    end
    check_eq("mem_en", mem_en, exp_en);
    if (exp_en) begin
      check_eq("mem_we", mem_we, exp_we);
      check_eq("mem_addr", mem_addr, exp_addr);
      if (exp_we) check_eq("mem_wdata", mem_wdata, h.data);
    end
    check_eq("cpu_ready", cpu_ready, exp_ready);
    check_eq("cpu_rvalid", cpu_rvalid, m_rv);
    check_eq("cpu_rdata", cpu_rdata, m_rv ? m_rv_val : '0);
    check_eq("rgb_out", rgb_out, m_rgb);
    check_eq("h_sync_out", h_sync_out, m_hs_out);
    check_eq("v_sync_out", v_sync_out, m_vs_out);

    r_rd = mem_en && !mem_we; r_wr = mem_en && mem_we;
    r_addr = mem_addr; r_wdata = mem_wdata;

    if (!reset) begin
      m_rv = 0;
      if (pop) begin
        void'(q.pop_front());
        if (!h.we) begin
          m_rv = 1;
          m_rv_val = in_fb ? ref_mem[h.addr] : '0;
        end else if (in_fb) begin
          ref_mem[h.addr] = h.data;
        end
      end
      if (cpu_req && exp_ready) q.push_back('{cpu_we, cpu_addr, cpu_wdata});
      if (m_vid) m_rgb = m_vid_val;
      else if (!m_disp_d) m_rgb = '0;
      m_vid = fetch;
      if (fetch) m_vid_val = ref_mem[pix_word(pixel_addr_x, pixel_addr_y)];
      m_disp_d = display_in;
      m_hs_out = m_hs_d; m_hs_d = h_sync_in;
      m_vs_out = m_vs_d; m_vs_d = v_sync_in;
      m_prev_x = pixel_addr_x; m_prev_y = pixel_addr_y;
      m_run = 1;
    end

    @(posedge clk);
    #1;
    if (r_wr) vram[r_addr] = r_wdata;
    mem_rdata = r_rd ? vram[r_addr] : DATA_W'($urandom);
  endtask

  initial begin
    int x, y, hold, rsel;
    for (int i = 0; i < 32768; i++) begin
      vram[i] = DATA_W'($urandom);
    end
    vram[0] = 12'hABC;
    vram[1] = 12'hABC;
    for (int i = 0; i < 32768; i++) ref_mem[i] = vram[i];

    reset = 1'b1;
    pixel_addr_x = '0; pixel_addr_y = '0;
    display_in = 1'b0; h_sync_in = 1'b1; v_sync_in = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_rdata = '0;
    model_reset();
    repeat (3) step();
    reset = 1'b0;

    x = 0; y = 0; hold = 3;
    for (int c = 0; c < 4000; c++) begin
      if (c > 50 && $urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        model_reset();
        repeat ($urandom_range(1, 3)) step();
        reset = 1'b0;
      end
      if (hold == 0) begin
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : 3;
        x = x + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 4);
        if (x >= 640) begin
          x = 0;
          y = (y + 1) % 480;
        end
      end else begin
        hold--;
      end
      pixel_addr_x = 10'(x);
      pixel_addr_y = 10'(y);
      display_in = ((c / 300) % 2) == 0;
      h_sync_in = 1'($urandom);
      v_sync_in = 1'($urandom);
      cpu_req = ($urandom_range(0, 2) != 0);
      cpu_we = 1'($urandom);
      rsel = $urandom_range(0, 9);
      if (rsel == 0)      cpu_addr = ADDR_W'(FB_WORDS + $urandom_range(0, 15));
      else if (rsel == 1) cpu_addr = ADDR_W'($urandom_range(FB_WORDS, 32767));
      else if (rsel < 8)  cpu_addr = ADDR_W'($urandom_range(0, 15));
      else                cpu_addr = ADDR_W'($urandom_range(0, FB_WORDS - 1));
      cpu_wdata = DATA_W'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_mem_arbiter.md
VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, meaning VRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 12, meaning VRAM word width (RGB444 pixel).
REQ-003 SHALL have parameter FB_WORDS, default 19200, meaning valid VRAM words (160x120 framebuffer).
REQ-004 SHALL have ports: clk  in  1  system clock, 100 MHz.
REQ-005 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: pixel_addr_x, pixel_addr_y  in  10 each  current scan position from the VGA timing block.
REQ-007 SHALL have ports: display_in, h_sync_in, v_sync_in  in  1 each  active-video flag and syncs from the VGA timing block.
REQ-008 SHALL have ports: cpu_req  in  1  CPU request valid; cpu_we  in  1  1=write, 0=read; cpu_addr  in  ADDR_W; cpu_wdata  in  DATA_W.
REQ-009 SHALL have ports: cpu_ready  out  1  request accepted when cpu_req&&cpu_ready at clk edge.
REQ-010 SHALL have ports: cpu_rvalid  out  1  one-cycle read-return strobe; cpu_rdata  out  DATA_W  read data.
REQ-011 SHALL have ports: mem_en, mem_we  out  1 each; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W, valid one clk after mem_en&&!mem_we.
REQ-012 SHALL have ports: rgb_out  out  DATA_W; h_sync_out, v_sync_out  out  1 each.

Function
REQ-013 SHALL issue at most one VRAM access (mem_en high) per clk; mem outputs are combinational from arbiter state.
REQ-014 SHALL hold prev_x/prev_y registers; video fetch is required in a cycle when display_in=1 and (pixel_addr_x,pixel_addr_y) differs from (prev_x,prev_y); prev regs update every clk.
REQ-015 SHALL issue the video fetch in the same cycle it is required, with absolute priority over CPU: mem_en=1, mem_we=0, mem_addr=(pixel_addr_y>>2)*160+(pixel_addr_x>>2).
REQ-016 SHALL load rgb_out from mem_rdata on the clk edge one cycle after a video fetch (rgb_out valid 2 clks after the position change).
REQ-017 SHALL load rgb_out with 0 on any clk edge where the 2-clk-delayed display_in is 0 and no video read data returns.
REQ-018 SHALL delay h_sync_in/v_sync_in by exactly 2 clks to h_sync_out/v_sync_out, aligned with rgb_out.
REQ-019 SHALL buffer CPU requests (we, addr, wdata) in a 2-entry in-order FIFO; cpu_ready = (count<2), derived from registered count only.
REQ-020 SHALL pop the FIFO head and issue it to VRAM in any cycle with no video fetch and count>0; push and pop in the same cycle leave count unchanged.
REQ-021 SHALL, for a popped write with addr<FB_WORDS, drive mem_en=1, mem_we=1, mem_addr, mem_wdata; no response is generated.
REQ-022 SHALL, for a popped read with addr<FB_WORDS, drive mem_en=1, mem_we=0 and pulse cpu_rvalid with cpu_rdata=mem_rdata on the next cycle.
REQ-023 SHALL, for popped addr>=FB_WORDS, keep mem_en=0; writes are dropped, reads return cpu_rvalid=1 with cpu_rdata=0 on the next cycle.
REQ-024 SHALL return CPU reads in acceptance order; cpu_rvalid never overlaps a video-return cycle's rgb_out update conflict (separate return tag register).
REQ-025 SHALL guarantee CPU service: with pixel changes every 4 clks, at least 3 of every 4 clks are available to the FIFO.
REQ-026 SHALL not fetch while display_in=0; the full blanking interval is CPU bandwidth.

Reset
REQ-027 SHALL, on reset assertion (asynchronously): FIFO count=0, cpu_ready=0 while reset high, cpu_rvalid=0, cpu_rdata=0, rgb_out=0, h_sync_out=v_sync_out=1, mem_en=0, return tags cleared.
REQ-028 SHALL set prev_x=prev_y=10'h3FF on reset so the first active position (0,0) triggers a fetch.
REQ-029 SHALL discard queued and in-flight CPU requests on reset mid-operation; no cpu_rvalid issued for them after release.

Verification
REQ-030 SHALL pass: position (0,0)->(4,0) display=1, mem_rdata=12'hABC -> mem_addr 0 then 1, rgb_out=12'hABC 2 clks after each change.
REQ-031 SHALL pass: CPU write addr 5 data 12'h123 then read addr 5 during blanking -> write issued, cpu_rvalid 1 clk after read issue, cpu_rdata=12'h123.
REQ-032 SHALL pass: CPU read queued in the same cycle as a pixel change -> video fetch issued first, CPU read next cycle, rvalid one cycle later.
REQ-033 SHALL pass: 3 back-to-back cpu_req with video fetch blocking -> cpu_ready low after 2 accepts, third accepted after first pop.
REQ-034 SHALL pass: read addr 19200 -> mem_en stays 0, cpu_rvalid=1, cpu_rdata=0.
REQ-035 SHALL pass: reset asserted with 2 queued reads -> no cpu_rvalid after release, cpu_ready=1 one clk after release.
